// File: rtl/dct_ctrl_pkg.sv
// Shared types and default constants for the 2D-DCT frame control path.
package dct_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} seq_state_t;

  localparam int DCT_ADDR_W    = 15;
  localparam int DCT_NUM_WORDS = 32768;
  localparam int DCT_PIPE_LAT  = 19;
  localparam int DCT_IN_W      = 64;
  localparam int DCT_OUT_W     = 96;

endpackage

// File: rtl/dct_valid_pipe.sv
// 1-bit valid delay line mirroring the datapath latency; shifts only when enabled.
module dct_valid_pipe #(
  parameter int DEPTH = 19
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic din_i,
  output logic tail_o,
  output logic any_o
);

  logic [DEPTH-1:0] stage_q;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)     stage_q <= '0;
        else if (en_i) stage_q <= din_i;
      end
    end else begin : g_multi
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)     stage_q <= '0;
        else if (en_i) stage_q <= {stage_q[DEPTH-2:0], din_i};
      end
    end
  endgenerate

  assign tail_o = stage_q[DEPTH-1];
  assign any_o  = |stage_q;

endmodule

// File: rtl/dct_frame_sequencer.sv
// Frame sequencer: read address generation, latency tracking, write address
// generation and completion pulse for one 2D-DCT image pass.
module dct_frame_sequencer
  import dct_ctrl_pkg::*;
#(
  parameter int ADDR_W    = DCT_ADDR_W,
  parameter int NUM_WORDS = DCT_NUM_WORDS,
  parameter int PIPE_LAT  = DCT_PIPE_LAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic              dp_en,
  output logic              in_ce,
  output logic [ADDR_W-1:0] in_addr,
  output logic [2:0]        row_phase,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_addr
);

  localparam int           CW   = ADDR_W + 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_WORDS - 1);

  seq_state_t    state_q, state_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic          active, pipe_tail, pipe_any;

  // Strobes are decoded from registered state; hold is the only live input gating them.
  assign active    = (state_q == RUN) || (state_q == DRAIN);
  assign busy      = active;
  assign done      = (state_q == DONE);
  assign dp_en     = active & ~hold;
  assign in_ce     = (state_q == RUN) & ~hold;
  assign out_we    = active & ~hold & pipe_tail;
  assign in_addr   = rd_cnt_q[ADDR_W-1:0];
  assign row_phase = rd_cnt_q[2:0];
  assign out_addr  = wr_cnt_q[ADDR_W-1:0];

  dct_valid_pipe #(.DEPTH(PIPE_LAT)) u_vpipe (
    .clk_i  (clk),
    .rst_i  (reset),
    .en_i   (dp_en),
    .din_i  (state_q == RUN),
    .tail_o (pipe_tail),
    .any_o  (pipe_any)
  );

  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (in_ce)  rd_cnt_d = rd_cnt_q + CW'(1);
    if (out_we) wr_cnt_d = wr_cnt_q + CW'(1);
    case (state_q)
      IDLE: if (start) begin
        state_d  = RUN;
        rd_cnt_d = '0;
        wr_cnt_d = '0;
      end
      RUN:   if (in_ce && rd_cnt_q == LAST) state_d = DRAIN;
      // An empty delay line here means nothing is left to write; never strand in DRAIN.
      DRAIN: if ((out_we && wr_cnt_q == LAST) || !pipe_any) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

endmodule

// File: tb/tb_dct_frame_sequencer.sv
// Directed bench: small frame (16 words, latency 3) scenarios plus one default-size frame.
module tb_dct_frame_sequencer;

  localparam int AW = 15;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic reset, start, hold, start_d, hold_d;

  logic          busy, done, dp_en, in_ce, out_we;
  logic [AW-1:0] in_addr, out_addr;
  logic [2:0]    row_phase;

  logic          d_busy, d_done, d_dp_en, d_in_ce, d_out_we;
  logic [AW-1:0] d_in_addr, d_out_addr;
  logic [2:0]    d_row_phase;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  initial begin
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  dct_frame_sequencer #(.ADDR_W(AW), .NUM_WORDS(16), .PIPE_LAT(3)) dut (
    .clk(clk), .reset(reset), .start(start), .hold(hold),
    .busy(busy), .done(done), .dp_en(dp_en), .in_ce(in_ce),
    .in_addr(in_addr), .row_phase(row_phase), .out_we(out_we), .out_addr(out_addr)
  );

  dct_frame_sequencer dut_def (
    .clk(clk), .reset(reset), .start(start_d), .hold(hold_d),
    .busy(d_busy), .done(d_done), .dp_en(d_dp_en), .in_ce(d_in_ce),
    .in_addr(d_in_addr), .row_phase(d_row_phase), .out_we(d_out_we), .out_addr(d_out_addr)
  );

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " busy"},      int'(busy),      0);
    chk({tag, " done"},      int'(done),      0);
    chk({tag, " dp_en"},     int'(dp_en),     0);
    chk({tag, " in_ce"},     int'(in_ce),     0);
    chk({tag, " in_addr"},   int'(in_addr),   0);
    chk({tag, " row_phase"}, int'(row_phase), 0);
    chk({tag, " out_we"},    int'(out_we),    0);
    chk({tag, " out_addr"},  int'(out_addr),  0);
  endtask

  // Called just after a rising edge; start is sampled at the next edge (E0).
  // Unheld cycle number t maps onto the basic frame: reads t=1..16, writes t=4..19.
  task automatic run_frame(input string tag, input int h_lo, input int h_hi,
                           input int s1, input int s2, input int rst_c);
    int t = 0;
    int nh = (h_hi >= h_lo) ? (h_hi - h_lo + 1) : 0;
    int dc = 20 + nh;
    bit held;
    string ct;
    start = 1'b1;
    for (int c = 1; c <= 26; c++) begin
      @(posedge clk); #1;
      start = (c == s1) || (c == s2);
      held  = (c >= h_lo) && (c <= h_hi);
      hold  = held;
      if (rst_c != 0 && c == rst_c)     reset = 1'b1;
      if (rst_c != 0 && c == rst_c + 1) reset = 1'b0;
      @(negedge clk);
      ct = $sformatf("%s c%0d", tag, c);
      if (rst_c != 0 && c >= rst_c) begin
        chk_zero(ct);
      end else begin
        if (!held) t++;
        chk({ct, " busy"},  int'(busy),  int'(c < dc));
        chk({ct, " done"},  int'(done),  int'(c == dc));
        chk({ct, " dp_en"}, int'(dp_en), int'(c < dc && !held));
        chk({ct, " in_ce"}, int'(in_ce), int'(!held && t >= 1 && t <= 16 && c < dc));
        if (in_ce) begin
          chk({ct, " in_addr"},   int'(in_addr),   t - 1);
          chk({ct, " row_phase"}, int'(row_phase), (t - 1) % 8);
        end
        chk({ct, " out_we"}, int'(out_we), int'(!held && t >= 4 && t <= 19 && c < dc));
        if (out_we) chk({ct, " out_addr"}, int'(out_addr), t - 4);
      end
    end
    start = 1'b0;
    hold  = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int nwr, bad, last_c, done_c, nrd;
    reset = 1'b1; start = 1'b0; hold = 1'b0; start_d = 1'b0; hold_d = 1'b0;
    #2;
    chk_zero("reset_noclk");
    chk("reset_noclk def busy", int'(d_busy), 0);
    clk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk_zero($sformatf("idle%0d", i));
    end
    @(posedge clk); #1;

    run_frame("basic",    0, -1, 0, 0,  0);
    run_frame("hold",     5,  7, 0, 0,  0);
    run_frame("ign_start",0, -1, 6, 19, 0);
    run_frame("midreset", 0, -1, 0, 0, 10);
    run_frame("after_rst",0, -1, 0, 0,  0);

    // Default-size frame: scoreboard on the write order plus event timing.
    nwr = 0; bad = 0; nrd = 0; last_c = -1; done_c = -1;
    start_d = 1'b1;
    for (int c = 1; c <= 32800; c++) begin
      @(posedge clk); #1;
      start_d = 1'b0;
      @(negedge clk);
      if (d_in_ce) begin
        if (int'(d_in_addr) != (nrd % 32768)) bad++;
        nrd++;
      end
      if (d_out_we) begin
        if (int'(d_out_addr) != nwr) bad++;
        nwr++;
        last_c = c;
      end
      if (d_done) begin
        done_c = c;
        break;
      end
    end
    chk("def order_errors", bad, 0);
    chk("def reads", nrd, 32768);
    chk("def writes", nwr, 32768);
    chk("def last_write_cycle", last_c, 32787);
    chk("def done_cycle", done_c, 32788);
    chk("def busy_at_done", int'(d_busy), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
